// File: rtl/accel_bus0_rr_sched.sv
// Round-robin grant scheduler for the bus0 AXI interconnect: one grant per
// transaction (address handshake through completion) with a stall watchdog.
module accel_bus0_rr_sched #(
  parameter int NREQ     = 4,
  parameter int IDX_BITS = 2,
  parameter int TMO_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ-1:0]     i_mask,
  input  logic                i_addr_fire,
  input  logic                i_done,
  input  logic [TMO_BITS-1:0] i_tmo_limit,
  output logic [NREQ-1:0]     o_gnt,
  output logic [IDX_BITS-1:0] o_gnt_idx,
  output logic                o_gnt_valid,
  output logic                o_busy,
  output logic                o_tmo,
  output logic [IDX_BITS-1:0] o_tmo_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [IDX_BITS:0]   NREQ_W   = (IDX_BITS+1)'(NREQ);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NREQ - 1);
  localparam logic [TMO_BITS-1:0] CNT_MAX  = '1;

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_BITS-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [TMO_BITS-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic                  tmo_q, tmo_d;
  logic [IDX_BITS-1:0]   tmo_idx_q, tmo_idx_d;

  logic [NREQ-1:0]       elig;
  logic [NREQ-1:0]       hit;
  logic [IDX_BITS-1:0]   cand [NREQ];
  logic [IDX_BITS-1:0]   sel_idx;
  logic                  any_elig;
  logic [IDX_BITS-1:0]   idx_next;
  logic [TMO_BITS-1:0]   cnt_inc;
  logic                  expire;

  assign elig     = i_req & ~i_mask;
  assign any_elig = |elig;

  // cand[gi] is the master visited gi steps after the round-robin pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDX_BITS:0] sum;
    assign sum      = {1'b0, rr_ptr_q} + (IDX_BITS+1)'(gi);
    assign cand[gi] = (sum >= NREQ_W) ? IDX_BITS'(sum - NREQ_W) : IDX_BITS'(sum);
    assign hit[gi]  = elig[cand[gi]];
  end

  // Scan from the farthest offset inward so the nearest hit wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hit[i]) sel_idx = cand[i];
    end
  end

  assign idx_next = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
  assign cnt_inc  = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
  assign expire   = (i_tmo_limit != '0) && (tmo_cnt_q == i_tmo_limit - 1'b1);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_d     = gnt_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = 1'b0;
    tmo_idx_d = tmo_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_d   = ST_GRANT;
          gnt_idx_d = sel_idx;
          gnt_d     = NREQ'(1) << sel_idx;
          tmo_cnt_d = '0;
        end
      end

      ST_GRANT: begin
        tmo_cnt_d = cnt_inc;
        if (i_addr_fire && i_done) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          rr_ptr_d = idx_next;
        end else if (expire) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          rr_ptr_d  = idx_next;
          tmo_d     = 1'b1;
          tmo_idx_d = gnt_idx_q;
        end else if (i_addr_fire) begin
          state_d = ST_DATA;
        end else if (!i_req[gnt_idx_q]) begin
          // Master withdrew before its address was taken; it keeps its turn.
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end

      ST_DATA: begin
        tmo_cnt_d = cnt_inc;
        if (i_done) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          rr_ptr_d = idx_next;
        end else if (expire) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          rr_ptr_d  = idx_next;
          tmo_d     = 1'b1;
          tmo_idx_d = gnt_idx_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
      tmo_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_q     <= gnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      tmo_idx_q <= tmo_idx_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_idx   = gnt_idx_q;
  assign o_gnt_valid = (state_q != ST_IDLE);
  assign o_busy      = (state_q == ST_DATA);
  assign o_tmo       = tmo_q;
  assign o_tmo_idx   = tmo_idx_q;

endmodule

// File: tb/tb_accel_bus0_rr_sched.sv
// Bench for accel_bus0_rr_sched: directed vector table, hand-written corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_accel_bus0_rr_sched;

  localparam int N = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [3:0] i_req = '0;
  logic [3:0] i_mask = '0;
  logic       i_addr_fire = 1'b0;
  logic       i_done = 1'b0;
  logic [7:0] i_tmo_limit = '0;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_idx;
  logic       o_gnt_valid;
  logic       o_busy;
  logic       o_tmo;
  logic [1:0] o_tmo_idx;

  int checks = 0;
  int errors = 0;

  accel_bus0_rr_sched #(.NREQ(4), .IDX_BITS(2), .TMO_BITS(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_mask(i_mask),
    .i_addr_fire(i_addr_fire), .i_done(i_done), .i_tmo_limit(i_tmo_limit),
    .o_gnt(o_gnt), .o_gnt_idx(o_gnt_idx), .o_gnt_valid(o_gnt_valid),
    .o_busy(o_busy), .o_tmo(o_tmo), .o_tmo_idx(o_tmo_idx)
  );

  always #5 i_clk = ~i_clk;

  // Transaction-level reference: phase 0 idle, 1 waiting for address, 2 waiting for completion.
  int m_phase, m_ptr, m_idx, m_age, m_tmo, m_tmo_idx;

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_idx = 0; m_age = 0; m_tmo = 0; m_tmo_idx = 0;
  endtask

  task automatic model_update();
    int lim;
    bit completed;
    lim = int'(i_tmo_limit);
    m_tmo = 0;
    if (m_phase == 0) begin
      for (int off = N - 1; off >= 0; off--) begin
        int k;
        k = (m_ptr + off) % N;
        if (i_req[k] && !i_mask[k]) begin
          m_idx = k;
          m_phase = 1;
        end
      end
      m_age = 0;
    end else begin
      completed = (m_phase == 1 && i_addr_fire && i_done) || (m_phase == 2 && i_done);
      if (completed) begin
        m_phase = 0;
        m_ptr = (m_idx + 1) % N;
      end else if (lim != 0 && m_age == lim - 1) begin
        m_phase = 0;
        m_tmo = 1;
        m_tmo_idx = m_idx;
        m_ptr = (m_idx + 1) % N;
      end else if (m_phase == 1 && i_addr_fire) begin
        m_phase = 2;
      end else if (m_phase == 1 && !i_req[m_idx]) begin
        m_phase = 0;
      end
      if (m_age < 255) m_age++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [3:0] eg;
    eg = (m_phase != 0) ? (4'b0001 << m_idx) : 4'b0000;
    chk("gnt", 32'(o_gnt), 32'(eg));
    chk("gnt_valid", 32'(o_gnt_valid), 32'(m_phase != 0));
    chk("busy", 32'(o_busy), 32'(m_phase == 2));
    chk("tmo", 32'(o_tmo), 32'(m_tmo));
    chk("tmo_idx", 32'(o_tmo_idx), 32'(m_tmo_idx));
    if (m_phase != 0) chk("gnt_idx", 32'(o_gnt_idx), 32'(m_idx));
    if (o_busy && !o_gnt_valid) chk("busy_implies_valid", 32'(o_busy), 32'(0));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_update();
    #1;
    compare_model();
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] mask,
                       input logic fire, input logic done);
    i_req = req; i_mask = mask; i_addr_fire = fire; i_done = done;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(o_gnt), 32'(0));
    chk("rst_valid", 32'(o_gnt_valid), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_tmo", 32'(o_tmo), 32'(0));
    chk("rst_gnt_idx", 32'(o_gnt_idx), 32'(0));
    chk("rst_tmo_idx", 32'(o_tmo_idx), 32'(0));
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       fire;
    logic       done;
    logic [3:0] gnt;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t vecs [17];

  initial begin
    // Full-request rotation: grant, fire, wait, done for each master, then wrap to 0.
    for (int m = 0; m < 4; m++) begin
      vecs[m*4+0] = '{4'hF, 1'b0, 1'b0, 4'b0001 << m, 1'b1, 1'b0};
      vecs[m*4+1] = '{4'hF, 1'b1, 1'b0, 4'b0001 << m, 1'b1, 1'b1};
      vecs[m*4+2] = '{4'hF, 1'b0, 1'b0, 4'b0001 << m, 1'b1, 1'b1};
      vecs[m*4+3] = '{4'hF, 1'b0, 1'b1, 4'b0000,      1'b0, 1'b0};
    end
    vecs[16] = '{4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};

    model_reset();
    #2;
    do_reset();

    for (int v = 0; v < 17; v++) begin
      drive(vecs[v].req, 4'b0000, vecs[v].fire, vecs[v].done);
      step();
      $display("vec %0d req=%b fire=%b done=%b -> gnt=%b valid=%b busy=%b",
               v, vecs[v].req, vecs[v].fire, vecs[v].done, o_gnt, o_gnt_valid, o_busy);
      chk("vec_gnt", 32'(o_gnt), 32'(vecs[v].gnt));
      chk("vec_valid", 32'(o_gnt_valid), 32'(vecs[v].valid));
      chk("vec_busy", 32'(o_busy), 32'(vecs[v].busy));
    end

    // Wrap: grant 1 then pointer at 2, request {0,1} wraps to 0; then masked-only request.
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0, 1'b0); step();
    chk("wrap_first", 32'(o_gnt), 32'(4'b0010));
    drive(4'b0010, 4'b0000, 1'b1, 1'b1); step();
    drive(4'b0011, 4'b0000, 1'b0, 1'b0); step();
    chk("wrap_gnt0", 32'(o_gnt), 32'(4'b0001));
    drive(4'b0011, 4'b0000, 1'b1, 1'b1); step();
    drive(4'b0001, 4'b0001, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("masked_no_grant", 32'(o_gnt_valid), 32'(0));
    end
    $display("seq wrap/mask done");

    // Same-cycle fire+done: never busy, pointer advances to 0.
    do_reset();
    drive(4'b1000, 4'b0000, 1'b0, 1'b0); step();
    chk("m3_gnt", 32'(o_gnt), 32'(4'b1000));
    drive(4'b1000, 4'b0000, 1'b1, 1'b1); step();
    chk("fd_busy", 32'(o_busy), 32'(0));
    chk("fd_valid", 32'(o_gnt_valid), 32'(0));
    drive(4'b1111, 4'b0000, 1'b0, 1'b0); step();
    chk("fd_next_gnt", 32'(o_gnt), 32'(4'b0001));
    $display("seq fire+done done");

    // Watchdog with limit 5: pulse exactly 5 cycles after the grant appears.
    do_reset();
    i_tmo_limit = 8'd5;
    drive(4'b0100, 4'b0000, 1'b0, 1'b0); step();
    chk("wd_gnt", 32'(o_gnt), 32'(4'b0100));
    drive(4'b0100, 4'b0000, 1'b1, 1'b0); step();
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("wd_hold", 32'(o_gnt_valid), 32'(1));
      chk("wd_no_tmo", 32'(o_tmo), 32'(0));
    end
    drive(4'b1100, 4'b0000, 1'b0, 1'b0); step();
    chk("wd_tmo", 32'(o_tmo), 32'(1));
    chk("wd_tmo_idx", 32'(o_tmo_idx), 32'(2));
    chk("wd_gnt_drop", 32'(o_gnt), 32'(0));
    step();
    chk("wd_next_gnt", 32'(o_gnt), 32'(4'b1000));
    chk("wd_pulse_end", 32'(o_tmo), 32'(0));
    $display("seq watchdog done");

    // Watchdog disabled: grant held indefinitely.
    do_reset();
    i_tmo_limit = 8'd0;
    drive(4'b0100, 4'b0000, 1'b0, 1'b0); step();
    drive(4'b0100, 4'b0000, 1'b1, 1'b0); step();
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    for (int c = 0; c < 300; c++) step();
    chk("nowd_valid", 32'(o_gnt_valid), 32'(1));
    chk("nowd_busy", 32'(o_busy), 32'(1));
    $display("seq watchdog disabled done");

    // Abort in GRANT keeps the pointer: master 1 wins again over master 2.
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0, 1'b0); step();
    drive(4'b0000, 4'b0000, 1'b0, 1'b0); step();
    chk("abort_idle", 32'(o_gnt_valid), 32'(0));
    drive(4'b0110, 4'b0000, 1'b0, 1'b0); step();
    chk("abort_regrant", 32'(o_gnt), 32'(4'b0010));
    $display("seq abort done");

    // Asynchronous reset mid-DATA, then pointer back at 0.
    do_reset();
    drive(4'b0110, 4'b0000, 1'b0, 1'b0); step();
    drive(4'b0110, 4'b0000, 1'b1, 1'b0); step();
    drive(4'b0100, 4'b0000, 1'b1, 1'b1); step();
    drive(4'b0100, 4'b0000, 1'b0, 1'b0); step();
    drive(4'b0100, 4'b0000, 1'b1, 1'b0); step();
    chk("pre_rst_busy", 32'(o_busy), 32'(1));
    chk("pre_rst_gnt", 32'(o_gnt), 32'(4'b0100));
    do_reset();
    drive(4'b0100, 4'b0000, 1'b0, 1'b0); step();
    chk("post_rst_gnt", 32'(o_gnt), 32'(4'b0100));
    $display("seq async reset done");

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0)
        i_tmo_limit = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      drive(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
      step();
    end
    $display("random traffic done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
